ct_f_spsram_2048x59_ctrl: RTL
=============================

Name: ct_f_spsram_2048x59_ctrl

Overview:
Request front-end that drives one 2048x59 single-port FPGA SRAM wrapper (CEN/GWEN/WEN active-low, synchronous read).
- After reset, performs a zero-fill sweep of all entries.
- Then accepts read/write requests over a valid/ready handshake and issues at most one SRAM access per cycle.
- Returns read data through a 3-entry response FIFO with valid/ready backpressure.
- Sits between the cache/buffer logic that owns the array contents and the SRAM wrapper.

Parameters:
ADDR_WIDTH, 11, SRAM address width
DATA_WIDTH, 59, SRAM data width
DEPTH, 2048, number of entries swept during init
INIT_EN, 1, 1 = zero-fill sweep after reset; 0 = skip sweep
RSP_DEPTH, 3, response FIFO entries (must be >= 3 for full throughput)

Ports:
forever_cpuclk  in   1   clock; also drives the SRAM CLK
cpurst          in   1   asynchronous, active-high reset
req_vld         in   1   request valid
req_rdy         out  1   request ready; registered-state function only, no path from req_vld or rsp_rdy
req_wr          in   1   1 = write, 0 = read
req_addr        in   11  entry index
req_wdata       in   59  write data
req_wmask       in   59  1 = write the bit; only bits 58, 57, 28 are used (see below)
rsp_vld         out  1   read data valid
rsp_rdy         in   1   consumer ready
rsp_rdata       out  59  read data
init_done       out  1   sweep complete; stays high until next reset
sram_a          out  11  to SRAM A
sram_cen        out  1   to SRAM CEN, active low
sram_gwen       out  1   to SRAM GWEN, active low
sram_wen        out  59  to SRAM WEN, per-bit, active low
sram_d          out  59  to SRAM D
sram_q          in   59  from SRAM Q, valid the cycle after a read edge

Behaviour:
- Reset values: req_rdy=0, rsp_vld=0, rsp_rdata=0, init_done=0, sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_a=0, sram_d=0. FIFO is emptied, pend=0, init counter=0.
- Reset asserted mid-operation aborts any in-flight read, discards FIFO contents and restarts the sweep at address 0.
- FSM states:
  - INIT: entered after reset when INIT_EN=1. Each cycle drives cen=0, gwen=0, wen=all 0, d=0, a=init_cnt, and increments init_cnt. After the write at DEPTH-1 the FSM moves to RUN. The sweep takes exactly DEPTH cycles; init_done rises in the first RUN cycle.
  - RUN: entered directly after reset when INIT_EN=0, with init_done=1 in the first cycle after reset release. RUN is terminal until reset.
- SRAM drive in RUN is combinational from the accept, fire = req_vld & req_rdy:
  - sram_cen = ~fire; sram_a = req_addr; sram_d = req_wdata; sram_gwen = ~(fire & req_wr).
  - The wrapper enables writes in three groups: bit 58, bits 57:29, bits 28:0. The block therefore drives sram_wen[58] = ~req_wmask[58], sram_wen[57:29] = all ~req_wmask[57], sram_wen[28:0] = all ~req_wmask[28]. Other mask bits are ignored.
  - When there is no fire, cen=1, gwen=1, wen=all 1.
- Read pipeline:
  - A read accepted in cycle T sets pend=1 for cycle T+1.
  - In T+1, sram_q is pushed into the FIFO.
  - rsp_vld is high from cycle T+2 with rsp_rdata equal to the FIFO head.
  - Reads complete in issue order. Writes generate no response.
- Flow control: occupancy = pend + FIFO count. req_rdy = RUN & (occupancy < RSP_DEPTH). Writes are gated by the same rule.
  - Sustained back-to-back reads with rsp_rdy=1 run at 1 per cycle.
  - With rsp_rdy=0, at most 3 reads are accepted, after which req_rdy=0.
  - A pop (rsp_vld & rsp_rdy) and a push in the same cycle leave the count unchanged. Overflow is impossible by construction; an assertion checks it.
- Ordering: a write in cycle T followed by a read of the same address in T+1 returns the new data.
- During INIT: req_rdy=0 and no request is observed.

Decomposition:
- Shared constants header: ADDR_WIDTH, DATA_WIDTH, the WEN group boundary bits (58, 57, 28) and the FSM state encodings (INIT=1'b0, RUN=1'b1).
- One sub-module: ct_f_spsram_rsp_fifo, a RSP_DEPTH-entry synchronous FIFO with push/pop/count/head.

Test Plan:
- Reset release with INIT_EN=1 -> cen low for exactly 2048 consecutive cycles with a = 0..2047, wen=0, d=0; init_done rises in cycle 2049; req_rdy=0 throughout the sweep.
- Write addr 0x155, data 0x5A5A_5A5A_5A5A_5A5, mask all 1; read 0x155 next cycle -> rsp_vld 2 cycles after the read accept, rdata equals the written data.
- Write addr 7 with mask bit58=1 only, data all 1 over a zero-filled entry; then read addr 7 -> rdata = 1<<58; sram_wen[57:0] = all 1 during the write.
- rsp_rdy=0, 5 reads presented -> exactly 3 accepted, req_rdy=0; raise rsp_rdy -> 3 responses returned in order, then the remaining 2 reads are accepted.
- 16 back-to-back reads with rsp_rdy=1 -> req_rdy stays 1 and one response per cycle after the 2-cycle latency.
- cpurst pulse while 2 responses are buffered and 1 read is pending -> rsp_vld=0 immediately, the sweep restarts at a=0, and no stale response appears afterward.

Source files
------------

// File: rtl/ct_f_spsram_2048x59_ctrl_pkg.sv
// Shared constants for the 2048x59 single-port SRAM request front-end:
// array geometry, write-enable group boundaries and controller states.
package ct_f_spsram_2048x59_ctrl_pkg;

  localparam int ADDR_WIDTH  = 11;
  localparam int DATA_WIDTH  = 59;
  localparam int WEN_HI_BIT  = 58;
  localparam int WEN_MID_BIT = 57;
  localparam int WEN_LO_BIT  = 28;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // The wrapper only honours three enable groups, so each group follows its representative mask bit.
  function automatic logic [DATA_WIDTH-1:0] wen_from_mask(input logic [DATA_WIDTH-1:0] mask);
    logic [DATA_WIDTH-1:0] wen;
    wen = {DATA_WIDTH{1'b1}};
    wen[WEN_HI_BIT] = ~mask[WEN_HI_BIT];
    wen[WEN_HI_BIT-1:WEN_LO_BIT+1] = {(WEN_HI_BIT-WEN_LO_BIT-1){~mask[WEN_MID_BIT]}};
    wen[WEN_LO_BIT:0] = {(WEN_LO_BIT+1){~mask[WEN_LO_BIT]}};
    return wen;
  endfunction

endpackage

// File: rtl/ct_f_spsram_rsp_fifo.sv
// Small synchronous FIFO holding read responses; head is the oldest entry.
module ct_f_spsram_rsp_fifo #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 59,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {WIDTH{1'b0}};
      end
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  ct_f_spsram_rsp_fifo_chk #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_chk (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .count (count)
  );

endmodule

// File: rtl/ct_f_spsram_rsp_fifo_chk.sv
// Occupancy checks for the response FIFO: never pushed when full, never popped when empty.
module ct_f_spsram_rsp_fifo_chk #(
  parameter int DEPTH = 3,
  parameter int CNT_W = 2
) (
  input logic             clk,
  input logic             rst,
  input logic             push,
  input logic             pop,
  input logic [CNT_W-1:0] count
);

  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count == CNT_W'(DEPTH))));

  no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop && (count == {CNT_W{1'b0}})));

endmodule

// File: rtl/ct_f_spsram_2048x59_ctrl.sv
// Front-end for a 2048x59 single-port SRAM: zero-fill sweep after reset, then
// one request per cycle with read data returned through a small response FIFO.
module ct_f_spsram_2048x59_ctrl
  import ct_f_spsram_2048x59_ctrl_pkg::*;
#(
  parameter int DEPTH     = 2048,
  parameter int INIT_EN   = 1,
  parameter int RSP_DEPTH = 3
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  pend;
  logic                  run;
  logic                  fire;
  logic                  pop;
  logic [CNT_W-1:0]      fifo_count;
  logic [OCC_W-1:0]      occ;

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state    <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
      init_cnt <= {ADDR_WIDTH{1'b0}};
      pend     <= 1'b0;
    end else begin
      state    <= state_nxt;
      init_cnt <= (state == ST_INIT) ? init_cnt + ADDR_WIDTH'(1) : init_cnt;
      pend     <= fire & ~req_wr;
    end
  end

  always_comb begin
    state_nxt = state;
    if ((state == ST_INIT) && (init_cnt == ADDR_WIDTH'(DEPTH - 1))) begin
      state_nxt = ST_RUN;
    end else begin
      state_nxt = state;
    end
  end

  // A read still in the SRAM pipeline reserves its FIFO slot, so backpressure never overflows.
  assign run       = (state == ST_RUN) & ~cpurst;
  assign occ       = {1'b0, fifo_count} + {{CNT_W{1'b0}}, pend};
  assign req_rdy   = run & (occ < OCC_W'(RSP_DEPTH));
  assign fire      = req_vld & req_rdy;
  assign init_done = run;
  assign rsp_vld   = (fifo_count != {CNT_W{1'b0}});
  assign pop       = rsp_vld & rsp_rdy;

  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = {DATA_WIDTH{1'b1}};
    sram_a    = {ADDR_WIDTH{1'b0}};
    sram_d    = {DATA_WIDTH{1'b0}};
    if (!cpurst) begin
      case (state)
        ST_INIT: begin
          sram_cen  = 1'b0;
          sram_gwen = 1'b0;
          sram_wen  = {DATA_WIDTH{1'b0}};
          sram_a    = init_cnt;
        end
        ST_RUN: begin
          sram_a    = req_addr;
          sram_d    = req_wdata;
          sram_cen  = ~fire;
          sram_gwen = ~(fire & req_wr);
          if (fire && req_wr) begin
            sram_wen = wen_from_mask(req_wmask);
          end else begin
            sram_wen = {DATA_WIDTH{1'b1}};
          end
        end
        default: begin
          sram_cen = 1'b1;
        end
      endcase
    end else begin
      sram_cen = 1'b1;
    end
  end

  ct_f_spsram_rsp_fifo #(.DEPTH(RSP_DEPTH), .WIDTH(DATA_WIDTH), .CNT_W(CNT_W)) u_rsp_fifo (
    .clk   (forever_cpuclk),
    .rst   (cpurst),
    .push  (pend),
    .pop   (pop),
    .din   (sram_q),
    .head  (rsp_rdata),
    .count (fifo_count)
  );

endmodule
